dlx_mem_arbiter: RTL



---
 rtl/dlx_mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dlx_mem_arbiter.sv
// Shares one single-ported memory bus between the DLX fetch port and data port (data wins ties).
// Optional access timeout is enabled by defining DLX_ARB_TIMEOUT_EN.
module dlx_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_address,
    output logic [DW-1:0] i_data_read,
    output logic          i_data_valid,
    input  logic          d_req,
    input  logic [AW-1:0] d_address,
    input  logic [DW-1:0] d_data_write,
    input  logic          d_write_enable,
    output logic [DW-1:0] d_data_read,
    output logic          d_data_valid,
    output logic          m_req,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_data_write,
    output logic          m_write_enable,
    input  logic [DW-1:0] m_data_read,
    input  logic          m_data_valid,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIAcc, StDAcc, StResp} state_e;

    state_e        r_state, w_state_next;
    logic          r_grant_d;
    logic          r_m_req;
    logic [AW-1:0] r_m_address;
    logic [DW-1:0] r_m_data_write;
    logic          r_m_write_enable;
    logic [DW-1:0] r_i_data_read;
    logic [DW-1:0] r_d_data_read;
    logic          w_acc;
    logic          w_done;
    logic          w_timeout;
    logic          w_err;

    assign w_acc  = (r_state == StIAcc) || (r_state == StDAcc);
    assign w_done = w_acc && m_data_valid;

`ifdef DLX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timed_out;

    // A completion on the same edge as the timeout counts as a normal completion.
    assign w_timeout = w_acc && !m_data_valid && (r_cnt == CW'(TIMEOUT - 1));
    assign w_err     = r_timed_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else if (r_state == StIdle) begin
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else if (w_acc) begin
            r_cnt       <= r_cnt + 1'b1;
            r_timed_out <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (d_req) begin
                    w_state_next = StDAcc;
                end else if (i_req) begin
                    w_state_next = StIAcc;
                end
            end
            StIAcc, StDAcc: begin
                if (w_done || w_timeout) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_d        <= 1'b0;
            r_m_req          <= 1'b0;
            r_m_address      <= '0;
            r_m_data_write   <= '0;
            r_m_write_enable <= 1'b0;
            r_i_data_read    <= '0;
            r_d_data_read    <= '0;
        end else begin
            if (r_state == StIdle) begin
                if (d_req) begin
                    r_grant_d        <= 1'b1;
                    r_m_req          <= 1'b1;
                    r_m_address      <= d_address;
                    r_m_data_write   <= d_data_write;
                    r_m_write_enable <= d_write_enable;
                end else if (i_req) begin
                    r_grant_d        <= 1'b0;
                    r_m_req          <= 1'b1;
                    r_m_address      <= i_address;
                    r_m_data_write   <= '0;
                    r_m_write_enable <= 1'b0;
                end
            end
            if (w_done || w_timeout) begin
                r_m_req          <= 1'b0;
                r_m_write_enable <= 1'b0;
                // Stores leave the load register alone; a timeout always zeroes it.
                if (r_grant_d) begin
                    if (w_timeout) begin
                        r_d_data_read <= '0;
                    end else if (!r_m_write_enable) begin
                        r_d_data_read <= m_data_read;
                    end
                end else begin
                    r_i_data_read <= w_timeout ? '0 : m_data_read;
                end
            end
        end
    end

    always_comb begin
        busy         = (r_state != StIdle);
        i_data_valid = (r_state == StResp) && !r_grant_d;
        d_data_valid = (r_state == StResp) && r_grant_d;
        err          = (r_state == StResp) && w_err;
    end

    assign m_req          = r_m_req;
    assign m_address      = r_m_address;
    assign m_data_write   = r_m_data_write;
    assign m_write_enable = r_m_write_enable;
    assign i_data_read    = r_i_data_read;
    assign d_data_read    = r_d_data_read;

endmodule
